// File: rtl/adc_spi_sampler.sv
// Serial ADC sequencer: one CS/s_clk conversion frame per sample period, all timing via clock enables.
// Publishes the DATA_BITS LSBs of each MSB-first frame through a valid/ack handshake with overrun flag.
`timescale 1ns/1ps
module adc_spi_sampler #(
  parameter int unsigned SCLK_HALF  = 16,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned DATA_BITS  = 12,
  parameter int unsigned SAMPLE_DIV = 2048
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sdata,
  output logic                 s_clk,
  output logic                 CS,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  input  logic                 sample_ack,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned HW = $clog2(SCLK_HALF);
  localparam int unsigned BW = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [TW-1:0]        r_timer;
  logic [HW-1:0]        r_half, w_half_nxt;
  logic [BW-1:0]        r_bits, w_bits_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_sclk, w_sclk_nxt;
  logic                 r_cs, w_cs_nxt;
  logic                 r_busy;
  logic [DATA_BITS-1:0] r_sample;
  logic                 r_valid;
  logic                 r_overrun;
  logic                 w_publish;
  logic                 w_start_tick;
  logic                 w_half_done;

  assign w_start_tick = enable & (r_timer == '0);
  assign w_half_done  = (r_half == HW'(SCLK_HALF - 1));

  // Conversion-rate timer; parked at zero while disabled so restart is immediate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (!enable || (r_timer == TW'(SAMPLE_DIV - 1))) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_half  <= '0;
      r_bits  <= '0;
      r_shift <= '0;
      r_sclk  <= 1'b1;
      r_cs    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_half  <= w_half_nxt;
      r_bits  <= w_bits_nxt;
      r_shift <= w_shift_nxt;
      r_sclk  <= w_sclk_nxt;
      r_cs    <= w_cs_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_half_nxt  = r_half;
    w_bits_nxt  = r_bits;
    w_shift_nxt = r_shift;
    w_sclk_nxt  = r_sclk;
    w_cs_nxt    = r_cs;
    w_publish   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_half_nxt = '0;
        w_sclk_nxt = 1'b1;
        w_cs_nxt   = 1'b1;
        if (w_start_tick) begin
          w_state_nxt = ST_CS_SETUP;
          w_cs_nxt    = 1'b0;
          w_bits_nxt  = '0;
        end
      end
      ST_CS_SETUP: begin
        if (w_half_done) begin
          w_half_nxt  = '0;
          w_sclk_nxt  = 1'b0;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_half_nxt = r_half + HW'(1);
        end
      end
      ST_SHIFT: begin
        if (!w_half_done) begin
          w_half_nxt = r_half + HW'(1);
        end else begin
          w_half_nxt = '0;
          if (!r_sclk) begin
            // Rising s_clk: capture MSB-first; only the trailing DATA_BITS survive.
            w_sclk_nxt  = 1'b1;
            w_shift_nxt = DATA_BITS'({r_shift, sdata});
            w_bits_nxt  = r_bits + BW'(1);
          end else if (r_bits == BW'(FRAME_BITS)) begin
            w_cs_nxt    = 1'b1;
            w_state_nxt = ST_CS_HOLD;
          end else begin
            w_sclk_nxt = 1'b0;
          end
        end
      end
      ST_CS_HOLD: begin
        if (w_half_done) begin
          w_half_nxt  = '0;
          w_publish   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_half_nxt = r_half + HW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output holding register with handshake; a publish over unconsumed data flags overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_publish) begin
        r_sample  <= r_shift;
        r_valid   <= 1'b1;
        r_overrun <= r_valid & ~sample_ack;
      end else if (r_valid && sample_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign s_clk        = r_sclk;
  assign CS           = r_cs;
  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;
  assign busy         = r_busy;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench for adc_spi_sampler at default parameters with a behavioural MSB-first ADC.
`timescale 1ns/1ps
module tb_adc_spi_sampler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sdata;
  logic        sample_ack;
  logic        s_clk;
  logic        CS;
  logic [11:0] sample;
  logic        sample_valid;
  logic        overrun;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] adc_frame;
  int bit_idx = 15;

  adc_spi_sampler dut (
    .clk(clk), .reset(reset), .enable(enable), .sdata(sdata),
    .s_clk(s_clk), .CS(CS), .sample(sample), .sample_valid(sample_valid),
    .sample_ack(sample_ack), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // ADC model: new bit on each s_clk falling edge while selected.
  always @(negedge CS) bit_idx = 15;
  always @(negedge s_clk) begin
    if (CS === 1'b0 && bit_idx >= 0) begin
      sdata = adc_frame[bit_idx];
      bit_idx--;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_cs_fall(input int limit, output int n);
    logic prev;
    prev = CS;
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (prev === 1'b1 && CS === 1'b0) return;
      prev = CS;
    end
    n = -1;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (sample_valid !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sample_valid !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; sample_ack = 1'b0; sdata = 1'b0; adc_frame = 16'h0;
    repeat (3) @(negedge clk);
    checks++; if (CS !== 1'b1) begin errors++; $display("FAIL reset_cs got %b exp 1", CS); end
    checks++; if (s_clk !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b exp 1", s_clk); end
    checks++; if (sample !== 12'h000) begin errors++; $display("FAIL reset_sample got %h exp 000", sample); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", sample_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (CS !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_disabled got cs=%b busy=%b exp cs=1 busy=0", CS, busy); end
  endtask

  task automatic test_capture();
    int n;
    adc_frame = 16'h0ABC;
    enable = 1'b1;
    wait_cs_fall(4, n);
    checks++; if (n != 1) begin errors++; $display("FAIL first_start got %0d exp 1", n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_frame got %b exp 1", busy); end
    wait_valid(1000, n);
    checks++; if (n != 544) begin errors++; $display("FAIL valid_latency got %0d exp 544", n); end
    checks++; if (sample !== 12'hABC) begin errors++; $display("FAIL capture_abc got %h exp abc", sample); end
    sample_ack = 1'b1;
    @(negedge clk);
    sample_ack = 1'b0;
    adc_frame = 16'hFFFF;
    wait_cs_fall(2100, n);
    checks++; if (n != 1503) begin errors++; $display("FAIL cs_restart got %0d exp 1503", n); end
    wait_valid(1000, n);
    checks++; if (n != 544 || sample !== 12'hFFF) begin errors++; $display("FAIL capture_fff got n=%0d sample=%h exp n=544 sample=fff", n, sample); end
    sample_ack = 1'b1;
    @(negedge clk);
    sample_ack = 1'b0;
  endtask

  task automatic test_frame_timing();
    int n, cs_low, falls, bad_half, sclk_bad, len;
    logic prev_s;
    cs_low = 0; falls = 0; bad_half = 0; sclk_bad = 0; len = 0; prev_s = 1'b1;
    wait_cs_fall(2100, n);
    checks++; if (n < 0) begin errors++; $display("FAIL timing_cs_fall got timeout exp fall"); end
    for (int i = 0; i < 2048; i++) begin
      if (i != 0) @(negedge clk);
      if (CS === 1'b0) cs_low++;
      if (CS === 1'b1 && s_clk !== 1'b1) sclk_bad++;
      if (s_clk !== prev_s) begin
        if (s_clk === 1'b0) falls++;
        if (len != 16) bad_half++;
        len = 1;
      end else begin
        len++;
      end
      prev_s = s_clk;
    end
    @(negedge clk);
    checks++; if (cs_low != 528) begin errors++; $display("FAIL cs_low_len got %0d exp 528", cs_low); end
    checks++; if (falls != 16) begin errors++; $display("FAIL sclk_falls got %0d exp 16", falls); end
    checks++; if (bad_half != 0) begin errors++; $display("FAIL sclk_half_len got %0d bad halves exp 0", bad_half); end
    checks++; if (sclk_bad != 0) begin errors++; $display("FAIL sclk_idle_high got %0d low cycles exp 0", sclk_bad); end
    checks++; if (CS !== 1'b0) begin errors++; $display("FAIL cs_period got cs=%b exp 0 at 2048", CS); end
  endtask

  task automatic test_handshake();
    int n;
    sample_ack = 1'b1;
    @(negedge clk);
    sample_ack = 1'b0;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL ack_clear got %b exp 0", sample_valid); end
    wait_valid(1000, n);
    checks++; if (n < 0) begin errors++; $display("FAIL hs_publish got timeout exp valid"); end
    repeat (3) @(negedge clk);
    sample_ack = 1'b1;
    @(negedge clk);
    sample_ack = 1'b0;
    checks++; if (sample_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL ack_late got valid=%b ovr=%b exp 0 0", sample_valid, overrun); end
    sample_ack = 1'b1;
    @(negedge clk);
    sample_ack = 1'b0;
    @(negedge clk);
    checks++; if (sample_valid !== 1'b0 || sample !== 12'hFFF) begin errors++; $display("FAIL ack_idle got valid=%b sample=%h exp 0 fff", sample_valid, sample); end
  endtask

  task automatic test_overrun();
    int n, ov;
    adc_frame = 16'h0123;
    wait_valid(2700, n);
    checks++; if (n < 0 || sample !== 12'h123) begin errors++; $display("FAIL ovr_first got n=%0d sample=%h exp 123", n, sample); end
    adc_frame = 16'h0456;
    ov = 0;
    for (int i = 0; i < 2060; i++) begin
      @(negedge clk);
      if (overrun === 1'b1) ov++;
    end
    checks++; if (ov != 1) begin errors++; $display("FAIL overrun_pulses got %0d exp 1", ov); end
    checks++; if (sample !== 12'h456 || sample_valid !== 1'b1) begin errors++; $display("FAIL overrun_data got sample=%h valid=%b exp 456 1", sample, sample_valid); end
    adc_frame = 16'h0789;
    wait_cs_fall(2100, n);
    repeat (543) @(negedge clk);
    sample_ack = 1'b1;
    @(negedge clk);
    sample_ack = 1'b0;
    checks++; if (sample !== 12'h789 || sample_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ack_publish got sample=%h valid=%b ovr=%b exp 789 1 0", sample, sample_valid, overrun); end
  endtask

  task automatic test_enable_drop();
    int n, falls;
    logic prev;
    sample_ack = 1'b1;
    @(negedge clk);
    sample_ack = 1'b0;
    adc_frame = 16'h0A5A;
    wait_cs_fall(2100, n);
    repeat (16 + 5 * 32) @(negedge clk);
    enable = 1'b0;
    wait_valid(1000, n);
    checks++; if (n < 0 || sample !== 12'hA5A) begin errors++; $display("FAIL drop_publish got n=%0d sample=%h exp a5a", n, sample); end
    sample_ack = 1'b1;
    @(negedge clk);
    sample_ack = 1'b0;
    falls = 0; prev = CS;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && CS === 1'b0) falls++;
      prev = CS;
    end
    checks++; if (falls != 0 || busy !== 1'b0) begin errors++; $display("FAIL disabled_idle got falls=%0d busy=%b exp 0 0", falls, busy); end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (CS !== 1'b0) begin errors++; $display("FAIL reenable_start got cs=%b exp 0", CS); end
  endtask

  task automatic test_reset_midframe();
    int n, cnt;
    repeat (16 + 8 * 32) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (CS !== 1'b1 || s_clk !== 1'b1) begin errors++; $display("FAIL rst_pins got cs=%b sclk=%b exp 1 1", CS, s_clk); end
    checks++; if (sample_valid !== 1'b0 || sample !== 12'h000 || busy !== 1'b0) begin errors++; $display("FAIL rst_state got valid=%b sample=%h busy=%b exp 0 000 0", sample_valid, sample, busy); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_cs_fall(4, n);
    checks++; if (n != 1) begin errors++; $display("FAIL rst_restart got %0d exp 1", n); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_no_publish got %b exp 0", sample_valid); end
    cnt = 1;
    while (CS === 1'b0 && cnt < 1000) begin
      @(negedge clk);
      if (CS === 1'b0) cnt++;
    end
    checks++; if (cnt != 528) begin errors++; $display("FAIL rst_frame_len got %0d exp 528", cnt); end
    wait_valid(100, n);
    checks++; if (n != 16 || sample !== 12'hA5A) begin errors++; $display("FAIL rst_frame_data got n=%0d sample=%h exp 16 a5a", n, sample); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_frame_timing();
    test_handshake();
    test_overrun();
    test_enable_drop();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_spi_sampler.md
Name: adc_spi_sampler

Overview:
- Sequences one serial ADC conversion per audio sample period. It generates the ADC chip select (CS, active-low) and serial clock (s_clk), and shifts in the MSB-first data frame.
- It publishes each 12-bit sample to the downstream audio datapath through a valid/ack handshake.
- It replaces free-running clock division: all timing derives from clk via clock enables, with a single clock domain.

Parameters:
- SCLK_HALF, 16: clk cycles per s_clk half-period. Minimum 2.
- FRAME_BITS, 16: s_clk cycles per conversion frame.
- DATA_BITS, 12: sample width. These are the LSBs of the frame. Must be ≤ FRAME_BITS.
- SAMPLE_DIV, 2048: clk cycles per conversion (48.8 kHz at 100 MHz).
- Legality constraint: SAMPLE_DIV ≥ SCLK_HALF*(2+2*FRAME_BITS)+2.

Ports:
- clk  in  1  system clock. All logic is on its rising edge only.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  1 = run periodic conversions.
- sdata  in  1  serial data from the ADC.
- s_clk  out  1  ADC serial clock. Registered; idles high.
- CS  out  1  ADC chip select. Registered; active-low; idles high.
- sample  out  DATA_BITS  last completed conversion.
- sample_valid  out  1  sample holds unconsumed data.
- sample_ack  in  1  consumer takes sample; effective only while sample_valid=1.
- overrun  out  1  one-cycle pulse when a new sample overwrites an unconsumed one.
- busy  out  1  1 while state ≠ IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - CS=1, s_clk=1, sample=0, sample_valid=0, overrun=0, busy=0.
  - All counters and the shift register are 0.
- Rate timer:
  - Counts 0..SAMPLE_DIV-1 and wraps, only while enable=1.
  - Held at 0 while enable=0.
  - start_tick = enable & (timer==0).
  - The first conversion starts on the first cycle with enable=1.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD.
  - IDLE: on start_tick, go to CS_SETUP; CS←0. Otherwise stay.
  - CS_SETUP: CS=0, s_clk=1 for SCLK_HALF cycles, then go to SHIFT and drive s_clk←0.
  - SHIFT:
    - s_clk toggles every SCLK_HALF cycles, giving FRAME_BITS low/high periods.
    - On the clk edge that drives s_clk 0→1, sdata shifts into the shift register LSB (MSB-first frame) and the bit count increments.
    - After the FRAME_BITS-th high half completes, go to CS_HOLD. s_clk stays 1; CS←1.
    - SHIFT lasts 2*SCLK_HALF*FRAME_BITS cycles (512 at defaults).
  - CS_HOLD:
    - CS=1, s_clk=1 for SCLK_HALF cycles.
    - Then sample←shift[DATA_BITS-1:0], sample_valid←1, and return to IDLE.
    - The upper FRAME_BITS-DATA_BITS bits are discarded.
- Timing at defaults:
  - CS low for SCLK_HALF*(1+2*FRAME_BITS) = 528 cycles.
  - sample_valid rises 544 cycles after CS falls.
  - 16 s_clk falling edges per frame, s_clk period 32 clk cycles.
- Handshake:
  - sample_ack=1 while sample_valid=1 clears sample_valid on the next edge.
  - sample_ack while sample_valid=0 is ignored.
- Overrun:
  - A publish while sample_valid=1 and no ack in the same cycle overwrites sample, keeps sample_valid=1, and pulses overrun for 1 cycle.
  - Publish and ack in the same cycle: the new sample is loaded, sample_valid stays 1, no overrun.
- enable falls mid-frame: the frame completes normally and publishes; the FSM then stays in IDLE. The timer holds at 0.
- start_tick outside IDLE (only reachable with an illegal parameter set): ignored, no frame corruption.
- reset asserted mid-frame: immediate return to reset values, with no partial sample published. After release, the next conversion starts on the first cycle with enable=1.

Test Plan:
- Data capture: ADC model drives frame 0x0ABC, sdata changing on s_clk falling edges. Required: sample=0xABC, sample_valid=1. Repeat with frame 0xFFFF → sample=0xFFF.
- Frame timing: enable held 1, SAMPLE_DIV=2048. Required:
  - CS falls every 2048 cycles and stays low 528 cycles.
  - Exactly 16 s_clk falling edges, each s_clk low/high half exactly 16 cycles.
  - s_clk=1 whenever CS=1.
- Handshake: ack 3 cycles after sample_valid rises → sample_valid=0 on the next edge, no overrun. Ack while sample_valid=0 → no effect.
- Overrun: never ack across two frames (0x123, then 0x456). Required: sample=0x456, sample_valid=1, overrun high exactly 1 cycle. Repeat with ack coincident with the second publish → no overrun.
- Enable drop at bit 5 of a frame: the frame completes and publishes. No further CS fall while enable=0. CS falls on the first cycle after enable returns to 1.
- Reset (reset=0) at bit 8: CS=1, s_clk=1, sample_valid=0, sample=0 immediately. No publish occurs. After release with enable=1, a full 528-cycle CS-low frame follows.
